// File: rtl/hcsr04_pkg.sv
// Shared definitions for the multi-channel HC-SR04 scan controller:
// FSM encoding (doubles as the debug display code), default timing and a width helper.
package hcsr04_pkg;

  localparam logic [3:0] DB_INICIAL  = 4'b0000;
  localparam logic [3:0] DB_PREP     = 4'b0001;
  localparam logic [3:0] DB_ENVIA    = 4'b0010;
  localparam logic [3:0] DB_ESPERA   = 4'b0011;
  localparam logic [3:0] DB_MEDE     = 4'b0100;
  localparam logic [3:0] DB_ARMAZENA = 4'b0101;
  localparam logic [3:0] DB_FALHA    = 4'b0110;
  localparam logic [3:0] DB_PROXIMO  = 4'b0111;
  localparam logic [3:0] DB_FINAL    = 4'b1111;

  typedef enum logic [3:0] {
    ST_INICIAL  = DB_INICIAL,
    ST_PREP     = DB_PREP,
    ST_ENVIA    = DB_ENVIA,
    ST_ESPERA   = DB_ESPERA,
    ST_MEDE     = DB_MEDE,
    ST_ARMAZENA = DB_ARMAZENA,
    ST_FALHA    = DB_FALHA,
    ST_PROXIMO  = DB_PROXIMO,
    ST_FINAL    = DB_FINAL
  } state_t;

  // 10 us trigger and 30 ms echo window at 50 MHz
  localparam int TRIG_CYCLES_50M    = 500;
  localparam int TIMEOUT_CYCLES_50M = 1500000;

  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hcsr04_echo_sync.sv
// Two-flop synchronizer for one raw echo line coming from a sensor.
module hcsr04_echo_sync (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hcsr04_scan_ctrl.sv
// Round-robin HC-SR04 controller: triggers each sensor in turn, times the echo,
// retries missing echoes and reports one result or error per channel.
module hcsr04_scan_ctrl
  import hcsr04_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int TRIG_CYCLES    = TRIG_CYCLES_50M,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_50M,
  parameter int MAX_RETRY      = 3,
  parameter int ECHO_W         = 22,
  parameter int CH_W           = width_of(N_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              medir,
  input  logic              continuo,
  input  logic [N_CH-1:0]   echo,
  output logic [N_CH-1:0]   trigger,
  output logic [ECHO_W-1:0] medida,
  output logic [CH_W-1:0]   canal,
  output logic              valido,
  output logic              erro,
  output logic              pronto,
  output logic              ocupado,
  output logic [3:0]        db_estado
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int TMR_W   = width_of(TMR_MAX);
  localparam int RTY_W   = width_of(MAX_RETRY + 1);

  localparam logic [TMR_W-1:0]  TMR_TRIG_END = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_TO_END   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ECHO_W-1:0] CNT_LIM      = ECHO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX      = RTY_W'(MAX_RETRY);
  localparam logic [CH_W-1:0]   CH_LAST      = CH_W'(N_CH - 1);

  if ((ECHO_W < $clog2(TIMEOUT_CYCLES)) || (N_CH < 1) || (N_CH > 16)) begin : g_param_chk
    $error("hcsr04_scan_ctrl: ECHO_W too narrow for TIMEOUT_CYCLES or N_CH outside 1..16");
  end

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [RTY_W-1:0]  rty_q, rty_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [ECHO_W-1:0] cnt_q, cnt_d;
  logic [ECHO_W-1:0] medida_q, medida_d;
  logic [CH_W-1:0]   canal_q, canal_d;
  logic [N_CH-1:0]   trigger_q, trigger_d;
  logic [N_CH-1:0]   echo_s;
  logic              echo_cur;

  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    hcsr04_echo_sync u_sync (
      .clock (clock),
      .reset (reset),
      .d_i   (echo[i]),
      .q_o   (echo_s[i])
    );
  end

  assign echo_cur = echo_s[ch_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_INICIAL;
      ch_q      <= '0;
      rty_q     <= '0;
      tmr_q     <= '0;
      cnt_q     <= '0;
      medida_q  <= '0;
      canal_q   <= '0;
      trigger_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      rty_q     <= rty_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      medida_q  <= medida_d;
      canal_q   <= canal_d;
      trigger_q <= trigger_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    rty_d    = rty_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    medida_d = medida_q;
    canal_d  = canal_q;
    valido   = 1'b0;
    erro     = 1'b0;
    pronto   = 1'b0;

    case (state_q)
      ST_INICIAL: begin
        tmr_d = '0;
        cnt_d = '0;
        ch_d  = '0;
        rty_d = '0;
        if (medir) state_d = ST_PREP;
      end
      ST_PREP: begin
        tmr_d   = '0;
        state_d = ST_ENVIA;
      end
      ST_ENVIA: begin
        if (tmr_q == TMR_TRIG_END) begin
          tmr_d   = '0;
          state_d = ST_ESPERA;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_ESPERA: begin
        // The first high cycle is counted here so medida equals the synchronized width.
        if (echo_cur) begin
          tmr_d   = '0;
          cnt_d   = ECHO_W'(1);
          state_d = ST_MEDE;
        end else if (tmr_q == TMR_TO_END) begin
          if (rty_q < RTY_MAX) begin
            rty_d   = rty_q + RTY_W'(1);
            state_d = ST_PREP;
          end else begin
            state_d = ST_FALHA;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_MEDE: begin
        if (!echo_cur)            state_d = ST_ARMAZENA;
        else if (cnt_q == CNT_LIM) state_d = ST_FALHA;
        else                      cnt_d   = cnt_q + ECHO_W'(1);
      end
      ST_ARMAZENA: begin
        valido  = 1'b1;
        state_d = ST_PROXIMO;
      end
      ST_FALHA: begin
        erro    = 1'b1;
        state_d = ST_PROXIMO;
      end
      ST_PROXIMO: begin
        rty_d = '0;
        tmr_d = '0;
        cnt_d = '0;
        if (ch_q < CH_LAST) begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ST_PREP;
        end else begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        pronto  = 1'b1;
        ch_d    = '0;
        state_d = continuo ? ST_PREP : ST_INICIAL;
      end
      default: state_d = ST_INICIAL;
    endcase

    // Result registers load on entry so medida/canal are already valid during the pulse.
    if (state_d == ST_ARMAZENA) begin
      medida_d = cnt_q;
      canal_d  = ch_q;
    end else if (state_d == ST_FALHA) begin
      medida_d = '1;
      canal_d  = ch_q;
    end

    trigger_d = '0;
    if (state_d == ST_ENVIA) trigger_d[ch_d] = 1'b1;
  end

  assign trigger   = trigger_q;
  assign medida    = medida_q;
  assign canal     = canal_q;
  assign ocupado   = (state_q != ST_INICIAL);
  assign db_estado = state_q;

endmodule
